// File: rtl/traffic_fsm.sv
// traffic_fsm: main-street / side-street traffic-light controller.
// Steps through the phases MAIN_G -> MAIN_Y -> (WALK) -> SIDE_G -> SIDE_Y
// on a per-second tick. Each green can be extended once per phase by the
// side-street vehicle sensor. Walk requests are latched until a WALK phase
// serves them. Lamp outputs are registered and are decoded from the next
// state, so they always match the state register.
module traffic_fsm #(
    parameter int T_BASE = 4,
    parameter int T_EXT  = 2,
    parameter int T_YEL  = 2,
    parameter int T_WALK = 3,
    parameter int CNT_W  = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick_1hz,
    input  logic       sensor_sync,
    input  logic       wr_sync,
    input  logic       prog_sync,
    output logic [2:0] main_lights,
    output logic [2:0] side_lights,
    output logic       walk_lamp,
    output logic [2:0] state_dbg
);

    typedef enum logic [2:0] {
        MAIN_G = 3'd0,
        MAIN_Y = 3'd1,
        WALK   = 3'd2,
        SIDE_G = 3'd3,
        SIDE_Y = 3'd4
    } state_t;

    // Phase durations, sized to the countdown register.
    localparam logic [CNT_W-1:0] L_BASE = CNT_W'(T_BASE);
    localparam logic [CNT_W-1:0] L_EXT  = CNT_W'(T_EXT);
    localparam logic [CNT_W-1:0] L_YEL  = CNT_W'(T_YEL);
    localparam logic [CNT_W-1:0] L_WALK = CNT_W'(T_WALK);
    localparam logic [CNT_W-1:0] L_ONE  = CNT_W'(1);

    // Lamp pattern for a state: {main[2:0], side[2:0], walk}.
    // Any unknown code shows all-red with no walk, the safest display.
    function automatic logic [6:0] lamp_decode(input state_t st);
        logic [6:0] lamps;
        case (st)
            MAIN_G:  lamps = {3'b001, 3'b100, 1'b0};
            MAIN_Y:  lamps = {3'b010, 3'b100, 1'b0};
            WALK:    lamps = {3'b100, 3'b100, 1'b1};
            SIDE_G:  lamps = {3'b100, 3'b001, 1'b0};
            SIDE_Y:  lamps = {3'b100, 3'b010, 1'b0};
            default: lamps = {3'b100, 3'b100, 1'b0};
        endcase
        return lamps;
    endfunction

    state_t           state_r;
    logic [CNT_W-1:0] cnt_r;
    logic             ext_r;
    logic             walk_pend_r;

    state_t           state_nxt_s;
    logic [CNT_W-1:0] cnt_nxt_s;
    logic             ext_nxt_s;
    logic             walk_nxt_s;
    logic             expiry_s;
    logic             illegal_s;
    logic             walk_req_s;

    assign expiry_s   = tick_1hz && (cnt_r == L_ONE);
    assign illegal_s  = (state_r > SIDE_Y);
    assign walk_req_s = walk_pend_r || wr_sync;
    assign state_dbg  = state_r;

    // Next-state, countdown, extension flag and walk latch.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        ext_nxt_s   = ext_r;
        walk_nxt_s  = walk_req_s;
        if (prog_sync) begin
            // Restart the sequence; a pending walk request survives.
            state_nxt_s = MAIN_G;
            cnt_nxt_s   = L_BASE;
            ext_nxt_s   = 1'b0;
        end else if (illegal_s) begin
            state_nxt_s = MAIN_G;
            cnt_nxt_s   = L_BASE;
            ext_nxt_s   = 1'b0;
        end else if (expiry_s) begin
            case (state_r)
                MAIN_G: begin
                    if (sensor_sync && !ext_r) begin
                        cnt_nxt_s = L_EXT;
                        ext_nxt_s = 1'b1;
                    end else begin
                        state_nxt_s = MAIN_Y;
                        cnt_nxt_s   = L_YEL;
                        ext_nxt_s   = 1'b0;
                    end
                end
                MAIN_Y: begin
                    if (walk_req_s) begin
                        // Entering WALK consumes the request, including a
                        // button press seen on this very edge.
                        state_nxt_s = WALK;
                        cnt_nxt_s   = L_WALK;
                        walk_nxt_s  = 1'b0;
                    end else begin
                        state_nxt_s = SIDE_G;
                        cnt_nxt_s   = L_BASE;
                    end
                end
                WALK: begin
                    state_nxt_s = SIDE_G;
                    cnt_nxt_s   = L_BASE;
                end
                SIDE_G: begin
                    if (sensor_sync && !ext_r) begin
                        cnt_nxt_s = L_EXT;
                        ext_nxt_s = 1'b1;
                    end else begin
                        state_nxt_s = SIDE_Y;
                        cnt_nxt_s   = L_YEL;
                        ext_nxt_s   = 1'b0;
                    end
                end
                SIDE_Y: begin
                    state_nxt_s = MAIN_G;
                    cnt_nxt_s   = L_BASE;
                end
                default: begin
                    state_nxt_s = MAIN_G;
                    cnt_nxt_s   = L_BASE;
                    ext_nxt_s   = 1'b0;
                end
            endcase
        end else if (tick_1hz) begin
            cnt_nxt_s = cnt_r - L_ONE;
        end else begin
            cnt_nxt_s = cnt_r;
        end
    end

    // State, timer, latches and registered lamp outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r     <= MAIN_G;
            cnt_r       <= L_BASE;
            ext_r       <= 1'b0;
            walk_pend_r <= 1'b0;
            main_lights <= 3'b001;
            side_lights <= 3'b100;
            walk_lamp   <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            cnt_r       <= cnt_nxt_s;
            ext_r       <= ext_nxt_s;
            walk_pend_r <= walk_nxt_s;
            {main_lights, side_lights, walk_lamp} <= lamp_decode(state_nxt_s);
        end
    end

endmodule

// File: tb/tb_traffic_fsm.sv
// Self-checking bench for traffic_fsm: directed phase sequences with literal
// expectations plus randomized traffic checked against a phase/seconds model.
module tb_traffic_fsm;

    localparam int T_BASE = 4;
    localparam int T_EXT  = 2;
    localparam int T_YEL  = 2;
    localparam int T_WALK = 3;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       tick_1hz = 1'b0;
    logic       sensor_sync = 1'b0;
    logic       wr_sync = 1'b0;
    logic       prog_sync = 1'b0;
    logic [2:0] main_lights;
    logic [2:0] side_lights;
    logic       walk_lamp;
    logic [2:0] state_dbg;

    int n_vec = 0;
    int n_err = 0;

    // Behavioural model: phase number, seconds left, extension used, walk wanted.
    int m_ph;
    int m_rem;
    bit m_ext;
    bit m_pend;

    // Phase order 0..4 = main green, main yellow, walk, side green, side yellow.
    int dur[5]      = '{T_BASE, T_YEL, T_WALK, T_BASE, T_YEL};
    int main_tab[5] = '{1, 2, 4, 4, 4};
    int side_tab[5] = '{4, 4, 4, 1, 2};

    traffic_fsm #(
        .T_BASE(T_BASE), .T_EXT(T_EXT), .T_YEL(T_YEL), .T_WALK(T_WALK), .CNT_W(4)
    ) dut (
        .clk(clk),
        .reset(reset),
        .tick_1hz(tick_1hz),
        .sensor_sync(sensor_sync),
        .wr_sync(wr_sync),
        .prog_sync(prog_sync),
        .main_lights(main_lights),
        .side_lights(side_lights),
        .walk_lamp(walk_lamp),
        .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        m_ph   = 0;
        m_rem  = T_BASE;
        m_ext  = 1'b0;
        m_pend = 1'b0;
    endtask

    // One clock edge of the light schedule, from the current inputs.
    task automatic model_step();
        bit served;
        served = 1'b0;
        if (prog_sync) begin
            m_ph  = 0;
            m_rem = T_BASE;
            m_ext = 1'b0;
        end else if (tick_1hz && m_rem == 1) begin
            if ((m_ph == 0 || m_ph == 3) && sensor_sync && !m_ext) begin
                m_rem = T_EXT;
                m_ext = 1'b1;
            end else begin
                if (m_ph == 0 || m_ph == 3) m_ext = 1'b0;
                if (m_ph == 1) begin
                    if (m_pend || wr_sync) begin
                        m_ph   = 2;
                        served = 1'b1;
                    end else begin
                        m_ph = 3;
                    end
                end else begin
                    m_ph = (m_ph == 0) ? 1 : (m_ph == 2) ? 3 : (m_ph == 3) ? 4 : 0;
                end
                m_rem = dur[m_ph];
            end
        end else if (tick_1hz) begin
            m_rem = m_rem - 1;
        end
        if (served) m_pend = 1'b0;
        else if (wr_sync) m_pend = 1'b1;
    endtask

    // Compare every DUT output with the model.
    task automatic cmp_model();
        chk("state", int'(state_dbg), m_ph);
        chk("main", int'(main_lights), main_tab[m_ph]);
        chk("side", int'(side_lights), side_tab[m_ph]);
        chk("walk", int'(walk_lamp), (m_ph == 2) ? 1 : 0);
    endtask

    task automatic cyc();
        @(posedge clk);
        model_step();
        @(negedge clk);
        cmp_model();
    endtask

    task automatic check_reset_lamps();
        chk("rst_main", int'(main_lights), 1);
        chk("rst_side", int'(side_lights), 4);
        chk("rst_walk", int'(walk_lamp), 0);
        chk("rst_state", int'(state_dbg), 0);
    endtask

    // Assert reset between edges, check lamps at once, release on a negedge.
    task automatic do_reset();
        wr_sync   = 1'b0;
        prog_sync = 1'b0;
        reset     = 1'b1;
        model_reset();
        #1;
        check_reset_lamps();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Step through a literal state sequence; the first entry is the current sample.
    task automatic run_seq(input string nm, input string s);
        for (int i = 0; i < s.len(); i++) begin
            if (i > 0) cyc();
            else cmp_model();
            chk(nm, int'(state_dbg), int'(s[i]) - 48);
        end
    endtask

    initial begin
        #1;
        // 1: plain cycle, period 12, no walk.
        tick_1hz = 1'b1;
        sensor_sync = 1'b0;
        do_reset();
        run_seq("plain", "00001133334400");

        // 2: sensor held, each green extended once, period 16.
        sensor_sync = 1'b1;
        do_reset();
        run_seq("sensor", "000000113333334400");
        sensor_sync = 1'b0;

        // 3: one-cycle walk pulse during MAIN_G cycle 2.
        do_reset();
        cmp_model();
        cyc();
        wr_sync = 1'b1;
        cyc();
        wr_sync = 1'b0;
        run_seq("walk", "00112223333440000113");

        // 4: reprogram in SIDE_G cycle 2 with a walk pending.
        do_reset();
        cmp_model();
        for (int i = 0; i < 6; i++) cyc();
        wr_sync = 1'b1;
        cyc();
        wr_sync   = 1'b0;
        prog_sync = 1'b1;
        cyc();
        prog_sync = 1'b0;
        chk("prog_main", int'(main_lights), 1);
        run_seq("prog", "0000112223");

        // 5: asynchronous reset in the middle of WALK.
        do_reset();
        wr_sync = 1'b1;
        cyc();
        wr_sync = 1'b0;
        begin
            int guard;
            guard = 0;
            while (m_ph != 2 && guard < 20) begin
                cyc();
                guard++;
            end
            if (guard >= 20) begin
                n_vec++;
                n_err++;
                $display("FAIL walk_reach: got phase %0d expected 2", m_ph);
            end
        end
        cyc();
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        check_reset_lamps();
        @(negedge clk);
        reset = 1'b0;
        run_seq("midwalk", "0000113333440");

        // 6: tick every third cycle, each phase three times longer.
        tick_1hz = 1'b0;
        do_reset();
        begin
            string s3;
            s3 = "000000000000111111333";
            cmp_model();
            chk("tick3", int'(state_dbg), int'(s3[0]) - 48);
            for (int e = 1; e < s3.len(); e++) begin
                tick_1hz = (e % 3 == 0);
                cyc();
                chk("tick3", int'(state_dbg), int'(s3[e]) - 48);
            end
        end

        // 7: randomized traffic with occasional reprogram and reset.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            tick_1hz    = ($urandom_range(0, 1) == 1);
            sensor_sync = ($urandom_range(0, 1) == 1);
            wr_sync     = ($urandom_range(0, 7) == 0);
            prog_sync   = ($urandom_range(0, 31) == 0);
            if ($urandom_range(0, 199) == 0) begin
                #2;
                reset = 1'b1;
                model_reset();
                #1;
                check_reset_lamps();
                @(negedge clk);
                reset = 1'b0;
            end else begin
                cyc();
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
